// File: rtl/cpu_mem_bridge.sv
// Shares one req/ack memory port between the CPU fetch and load/store ports.
// Serves one transaction at a time, with load/store priority and a timeout on hung accesses.
//   state | meaning
//   IDLE  | sample fetch / load-store requests
//   FETCH | fetch request on the memory port, waiting for ack
//   LDST  | load/store request on the memory port, waiting for ack
//   RESP  | valid pulse to the CPU; the CPU drops its request this cycle
module cpu_mem_bridge #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                TIMEOUT  = 64,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(16'hDEAD)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_pc_rd,
    input  logic [ADDR_W-1:0] i_pc_addr,
    output logic [DATA_W-1:0] o_pc_rddata,
    output logic              o_pc_valid,
    input  logic              i_ldst_rd,
    input  logic              i_ldst_wr,
    input  logic [ADDR_W-1:0] i_ldst_addr,
    input  logic [DATA_W-1:0] i_ldst_wrdata,
    output logic [DATA_W-1:0] o_ldst_rddata,
    output logic              o_ldst_valid,
    output logic              o_stall,
    output logic              o_mem_req,
    output logic              o_mem_wr,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wrdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rddata,
    output logic              o_timeout_err,
    output logic              o_busy
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LDST  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;
    logic             expired;
    logic [DATA_W-1:0] done_data;

    // Abort when this no-ack cycle would bring the count to TIMEOUT; an ack in that cycle wins.
    assign expired   = (TIMEOUT > 0) && (tmo_cnt == CNT_LAST) && !i_mem_ack;
    assign done_data = i_mem_ack ? i_mem_rddata : ERR_DATA;

    assign o_stall = (i_pc_rd & ~o_pc_valid) | ((i_ldst_rd | i_ldst_wr) & ~o_ldst_valid);
    assign o_busy  = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            tmo_cnt       <= '0;
            o_mem_req     <= 1'b0;
            o_mem_wr      <= 1'b0;
            o_mem_addr    <= '0;
            o_mem_wrdata  <= '0;
            o_pc_rddata   <= '0;
            o_pc_valid    <= 1'b0;
            o_ldst_rddata <= '0;
            o_ldst_valid  <= 1'b0;
            o_timeout_err <= 1'b0;
        end else begin
            o_pc_valid   <= 1'b0;
            o_ldst_valid <= 1'b0;
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (i_ldst_rd || i_ldst_wr) begin
                        o_mem_addr   <= i_ldst_addr;
                        o_mem_wrdata <= i_ldst_wrdata;
                        o_mem_wr     <= i_ldst_wr;
                        o_mem_req    <= 1'b1;
                        state        <= LDST;
                    end else if (i_pc_rd) begin
                        o_mem_addr <= i_pc_addr;
                        o_mem_wr   <= 1'b0;
                        o_mem_req  <= 1'b1;
                        state      <= FETCH;
                    end
                end
                FETCH, LDST: begin
                    if (i_mem_ack || expired) begin
                        o_mem_req <= 1'b0;
                        state     <= RESP;
                        if (!i_mem_ack) begin
                            o_timeout_err <= 1'b1;
                        end
                        if (state == FETCH) begin
                            o_pc_valid  <= 1'b1;
                            o_pc_rddata <= done_data;
                        end else begin
                            o_ldst_valid <= 1'b1;
                            if (!o_mem_wr) begin
                                o_ldst_rddata <= done_data;
                            end
                        end
                    end else if (TIMEOUT > 0) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
